// File: rtl/reset_boot_ctrl_if.sv
// Board-facing reset/boot signals: raw pins and UART request in, system reset and boot info out.
interface reset_boot_ctrl_if;
    logic       key_n;
    logic       boot_sw;
    logic       uart_reset;
    logic       sys_reset;
    logic       boot_mode;
    logic [1:0] reset_cause;

    modport master (
        output key_n, boot_sw, uart_reset,
        input  sys_reset, boot_mode, reset_cause
    );

    modport slave (
        input  key_n, boot_sw, uart_reset,
        output sys_reset, boot_mode, reset_cause
    );
endinterface

// File: rtl/reset_boot_ctrl.sv
// Stretched system reset: synchronised/debounced key and boot switch, UART reset merge,
// boot mode captured on the release edge.
module reset_boot_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 1024,
    parameter int CNT_BITS          = 21
) (
    input  logic               clk,
    input  logic               reset,
    reset_boot_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {POR, HOLD, RUN} state_t;

    localparam logic [CNT_BITS-1:0] DB_LAST   = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] POR_LAST  = CNT_BITS'(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(RESET_HOLD_CYCLES - 1);
    // bit 0 = key_n (idle high), bit 1 = boot_sw (idle low)
    localparam logic [1:0] IN_RST = 2'b01;

    logic [1:0]               raw;
    logic [1:0]               sync1;
    logic [1:0]               sync2;
    logic [1:0]               db;
    logic [1:0][CNT_BITS-1:0] db_cnt;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic                sys_reset_q;
    logic                boot_q;
    logic [1:0]          cause_q;
    logic                key_req;
    logic                req;
    logic [1:0]          req_cause;

    assign raw = {bus.boot_sw, bus.key_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= IN_RST;
            sync2  <= IN_RST;
            db     <= IN_RST;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign key_req   = ~db[0];
    assign req       = key_req | bus.uart_reset;
    assign req_cause = key_req ? 2'b01 : 2'b10;

    // Requests are ignored in POR; the debouncers are still settling there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= POR;
            cnt         <= '0;
            sys_reset_q <= 1'b1;
            boot_q      <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            case (state)
                POR: begin
                    if (cnt >= POR_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (req) begin
                        cnt     <= '0;
                        cause_q <= req_cause;
                    end else if (cnt >= HOLD_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        sys_reset_q <= 1'b0;
                        boot_q      <= db[1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (req) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        sys_reset_q <= 1'b1;
                        cause_q     <= req_cause;
                    end
                end
                default: begin
                    state       <= POR;
                    cnt         <= '0;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sys_reset   = sys_reset_q;
    assign bus.boot_mode   = boot_q;
    assign bus.reset_cause = cause_q;
endmodule

// File: tb/tb_reset_boot_ctrl.sv
// Random key/switch/UART/reset traffic against a timestamp-based reference model.
module tb_reset_boot_ctrl;
    localparam int D = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset;
    reset_boot_ctrl_if bus();

    reset_boot_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .RESET_HOLD_CYCLES(H),
        .CNT_BITS         (21)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: edge index t, edge of last reset, edge of last honoured request.
    int         t = 0;
    int         rst_t = 0;
    int         last_req = -1000;
    logic       qk1 = 1, qk2 = 1, qs1 = 0, qs2 = 0;
    logic       dbk = 1, dbs = 0;
    int         evk = 0, evs = 0;
    logic       hk[$];
    logic       hs[$];
    logic       e_sys = 1, e_boot = 0;
    logic [1:0] e_cause = 0;

    function automatic logic all_differ(input logic h[$], input logic v);
        foreach (h[i]) if (h[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        logic sk, ss, rq, prev;
        t++;
        if (reset) begin
            qk1 = 1; qk2 = 1; qs1 = 0; qs2 = 0;
            dbk = 1; dbs = 0; evk = t; evs = t;
            hk.delete(); hs.delete();
            rst_t = t; last_req = -1000;
            e_sys = 1; e_boot = 0; e_cause = 0;
            return;
        end
        sk = qk2; qk2 = qk1; qk1 = bus.key_n;
        ss = qs2; qs2 = qs1; qs1 = bus.boot_sw;
        rq = !dbk || bus.uart_reset;
        // Requests count only once the power-on settle window (D+2 edges) is over
        if (rq && t > rst_t + D + 2) begin
            last_req = t;
            e_cause  = !dbk ? 2'b01 : 2'b10;
        end
        prev  = e_sys;
        e_sys = (t < rst_t + D + 2 + H) || (t < last_req + H);
        if (prev && !e_sys) e_boot = dbs;
        hk.push_back(sk); if (hk.size() > D) void'(hk.pop_front());
        hs.push_back(ss); if (hs.size() > D) void'(hs.pop_front());
        if (t - evk >= D && all_differ(hk, dbk)) begin dbk = sk; evk = t; end
        if (t - evs >= D && all_differ(hs, dbs)) begin dbs = ss; evs = t; end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("sys_reset",   32'(bus.sys_reset),   32'(e_sys));
        chk("boot_mode",   32'(bus.boot_mode),   32'(e_boot));
        chk("reset_cause", 32'(bus.reset_cause), 32'(e_cause));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset          = 1'b1;
        bus.key_n      = 1'b1;
        bus.boot_sw    = 1'b1;
        bus.uart_reset = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(20);
        for (int seg = 0; seg < 400; seg++) begin
            int act;
            act = $urandom_range(0, 11);
            case (act)
                0, 1: idle($urandom_range(3, 30));
                2, 3: begin
                    bus.uart_reset = 1'b1;
                    idle($urandom_range(1, 3));
                    bus.uart_reset = 1'b0;
                    idle($urandom_range(0, 12));
                end
                4, 5, 6: begin
                    bus.key_n = 1'b0;
                    idle($urandom_range(1, 25));
                    bus.key_n = 1'b1;
                    idle($urandom_range(0, 20));
                end
                7, 8: begin
                    bus.boot_sw = ~bus.boot_sw;
                    idle($urandom_range(1, 15));
                end
                9: begin
                    // key press with UART requests landing around its debounce point
                    bus.key_n = 1'b0;
                    idle($urandom_range(8, 11));
                    bus.uart_reset = 1'b1;
                    idle($urandom_range(1, 3));
                    bus.uart_reset = 1'b0;
                    bus.key_n = 1'b1;
                    idle($urandom_range(10, 25));
                end
                10: begin
                    bus.uart_reset = 1'b1;
                    idle(1);
                    bus.uart_reset = 1'b0;
                    idle($urandom_range(1, 3));
                    bus.uart_reset = 1'b1;
                    idle(1);
                    bus.uart_reset = 1'b0;
                    idle($urandom_range(4, 10));
                end
                default: begin
                    reset = 1'b1;
                    idle($urandom_range(1, 3));
                    reset = 1'b0;
                    idle($urandom_range(0, 25));
                end
            endcase
        end
        idle(30);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/reset_boot_ctrl.md
Name: reset_boot_ctrl

Overview:
System reset and boot-mode source that sits directly upstream of the top-level reset net and the `boot_mode` input of the memory unit. It synchronises and debounces the external reset key and the boot-mode switch, and merges in the UART magic-sequence reset request. It produces a stretched, glitch-free `sys_reset` and a `boot_mode` value that is latched only when reset is released. The block runs entirely in the 50 MHz CPU domain, so downstream logic uses both outputs without further synchronisers.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles an input must differ from its debounced value before that value flips (20 ms at 50 MHz)
RESET_HOLD_CYCLES, 1024, cycles `sys_reset` stays high after the last reset request is removed
CNT_BITS, 21, width of the internal counters; must hold DEBOUNCE_CYCLES+2 and RESET_HOLD_CYCLES

Ports:
clk  input  1  50 MHz CPU clock
reset  input  1  power-on/global reset; synchronous, active-high
key_n  input  1  external reset button; asynchronous, active-low
boot_sw  input  1  external boot-mode switch; asynchronous
uart_reset  input  1  reset request from the UART magic-sequence detector; synchronous to clk; pulse or level
sys_reset  output  1  system reset to CPU, memory unit and cache controller; active-high, registered
boot_mode  output  1  boot mode latched at reset release; 0 = ROM bootloader, 1 = alternate
reset_cause  output  2  source of the last reset: 00 = POR, 01 = key, 10 = UART, 11 = unused

Behaviour:
- Reset (`reset`=1 at a clk edge):
  - state=POR, counters=0, sys_reset=1, boot_mode=0, reset_cause=00.
  - key_n synchroniser and debounced key = 1; boot_sw synchroniser and debounced sw = 0.
- Synchronisers: key_n and boot_sw each pass through a 2-FF synchroniser (2-cycle latency). No other logic touches the raw pins.
- Debouncer, one per input:
  - The counter increments while the synced value differs from the debounced value, and clears to 0 on any cycle where they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value flips and the counter clears.
- key_req = debounced key == 0 (level: a held button holds reset).
- FSM, all outputs registered:
  - POR: sys_reset=1. Count DEBOUNCE_CYCLES+2 cycles so both debouncers settle, then go to HOLD with the counter cleared.
  - HOLD: sys_reset=1.
    - While key_req or uart_reset: counter=0, and reset_cause takes the requester (key wins if both).
    - Otherwise the counter increments. When it reaches RESET_HOLD_CYCLES-1, go to RUN.
  - RUN: sys_reset=0.
    - key_req or uart_reset at edge N: go to HOLD, sys_reset=1 visible after edge N (1-cycle latency).
    - reset_cause is updated (key over UART on a simultaneous request).
- Release timing:
  - sys_reset is high for exactly RESET_HOLD_CYCLES cycles after the last cycle with a request asserted.
  - The HOLD->RUN transition is the same edge at which sys_reset falls and boot_mode <= debounced sw.
- boot_mode: constant throughout RUN; sw changes during RUN have no effect until the next reset release.
- reset_cause: holds its value through RUN and is readable after release; a POR-only sequence leaves it at 00.
- Reset mid-operation: `reset` overrides any state and returns to POR with the reset values above.
- Counters saturate and never wrap. uart_reset held high indefinitely keeps the block in HOLD.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4 unless stated.

1. Power-on: reset=1 for 3 cycles then 0, key_n=1, boot_sw=1 constant -> sys_reset=1 for exactly 14 edges after reset release (10 POR + 4 HOLD), then 0; boot_mode=1, reset_cause=00.
2. UART reset: in RUN, uart_reset=1 for 1 cycle at edge N -> sys_reset=1 from edge N to edge N+4, falls after edge N+4; reset_cause=10.
3. Key glitch and key hold:
   - key_n=0 for 5 cycles -> no reset; sys_reset stays 0.
   - key_n=0 for 20 cycles -> sys_reset rises 2+8 edges after the press and stays high while pressed; falls 4 cycles after the debounced release; reset_cause=01.
4. Boot switch latch: boot_sw toggled 0->1 in RUN -> boot_mode stays 0. Then uart_reset pulse -> boot_mode=1 at the same edge sys_reset falls.
5. Simultaneous requests: debounced key press and uart_reset in the same cycle -> reset_cause=01. A second uart_reset during HOLD restarts the 4-cycle count and sets reset_cause=10.
6. Reset during HOLD: assert reset mid-HOLD -> sys_reset=1, reset_cause=00, boot_mode=0; the full 14-cycle POR sequence repeats.
